// File: rtl/cond_decode_if.sv
// Handshake and decode bundle between IF/ID, the decode stage and EX.
// The master drives the upstream fields and out_ready. The slave is the stage.
interface cond_decode_if #(
    parameter int CMD_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       cond;
    logic [1:0]       mode;
    logic [3:0]       op_code;
    logic             s_in;
    logic [3:0]       status;
    logic             hazard;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [CMD_W-1:0] exe_cmd;
    logic             mem_read;
    logic             mem_write;
    logic             wb_en;
    logic             b;
    logic             s_out;
    logic             illegal;

    modport master (
        output in_valid, cond, mode, op_code, s_in, status, hazard, flush, out_ready,
        input  in_ready, out_valid, exe_cmd, mem_read, mem_write, wb_en, b, s_out, illegal
    );

    modport slave (
        input  in_valid, cond, mode, op_code, s_in, status, hazard, flush, out_ready,
        output in_ready, out_valid, exe_cmd, mem_read, mem_write, wb_en, b, s_out, illegal
    );
endinterface

// File: rtl/cond_decode_stage.sv
// Registered ARM-subset decode stage: opcode decode, condition check against
// NZCV, and squashing of the branch-shadow slots after a taken branch.
module cond_decode_stage #(
    parameter int CMD_W       = 4,
    parameter int FLUSH_SLOTS = 1,
    parameter int NV_EXECUTES = 0
) (
    input logic          clk,
    input logic          rst_n,
    cond_decode_if.slave bus
);
    logic [3:0] d_cmd;
    logic       d_mr, d_mw, d_wb, d_b, d_s, d_ill;
    logic       cond_pass;
    logic       accept;
    logic       kill;
    logic [3:0] shadow_cnt;
    logic       n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = bus.status;

    assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !bus.hazard && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;
    // Illegal ops are never squashed, so the fault always reaches EX.
    assign kill         = !d_ill && (!cond_pass || shadow_cnt != 4'd0);

    // Map {mode, op_code, s_in} onto the EX command and control bits.
    always_comb begin
        d_cmd = 4'b0000;
        d_mr  = 1'b0;
        d_mw  = 1'b0;
        d_wb  = 1'b0;
        d_b   = 1'b0;
        d_s   = 1'b0;
        d_ill = 1'b0;
        case (bus.mode)
            2'b00: begin
                d_wb = 1'b1;
                d_s  = bus.s_in;
                case (bus.op_code)
                    4'b1101: d_cmd = 4'b0001;
                    4'b1111: d_cmd = 4'b1001;
                    4'b0100: d_cmd = 4'b0010;
                    4'b0101: d_cmd = 4'b0011;
                    4'b0010: d_cmd = 4'b0100;
                    4'b0110: d_cmd = 4'b0101;
                    4'b0000: d_cmd = 4'b0110;
                    4'b1100: d_cmd = 4'b0111;
                    4'b0001: d_cmd = 4'b1000;
                    4'b1010: begin d_cmd = 4'b0100; d_wb = 1'b0; d_s = 1'b1; end
                    4'b1000: begin d_cmd = 4'b0110; d_wb = 1'b0; d_s = 1'b1; end
                    default: begin d_wb = 1'b0; d_s = 1'b0; d_ill = 1'b1; end
                endcase
            end
            2'b01: begin
                d_cmd = 4'b0010;
                d_mr  = bus.s_in;
                d_wb  = bus.s_in;
                d_mw  = !bus.s_in;
            end
            2'b10:   d_b   = 1'b1;
            default: d_ill = 1'b1;
        endcase
    end

    // Evaluate the condition field against the flags presented with the op.
    always_comb begin
        case (bus.cond)
            4'h0:    cond_pass = z_f;
            4'h1:    cond_pass = !z_f;
            4'h2:    cond_pass = c_f;
            4'h3:    cond_pass = !c_f;
            4'h4:    cond_pass = n_f;
            4'h5:    cond_pass = !n_f;
            4'h6:    cond_pass = v_f;
            4'h7:    cond_pass = !v_f;
            4'h8:    cond_pass = c_f && !z_f;
            4'h9:    cond_pass = !c_f || z_f;
            4'hA:    cond_pass = (n_f == v_f);
            4'hB:    cond_pass = (n_f != v_f);
            4'hC:    cond_pass = !z_f && (n_f == v_f);
            4'hD:    cond_pass = z_f || (n_f != v_f);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = (NV_EXECUTES != 0);
        endcase
    end

    // Output register and branch-shadow counter; flush outranks accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.exe_cmd   <= '0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.wb_en     <= 1'b0;
            bus.b         <= 1'b0;
            bus.s_out     <= 1'b0;
            bus.illegal   <= 1'b0;
            shadow_cnt    <= 4'd0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
            shadow_cnt    <= 4'd0;
        end else if (accept) begin
            // Every accepted slot inside the shadow consumes one count; a
            // branch caught there is killed and so cannot reload it.
            if (shadow_cnt != 4'd0)
                shadow_cnt <= shadow_cnt - 4'd1;
            else if (!kill && d_b)
                shadow_cnt <= 4'(FLUSH_SLOTS);
            bus.out_valid <= !kill;
            bus.exe_cmd   <= kill ? '0 : CMD_W'(d_cmd);
            bus.mem_read  <= d_mr && !kill;
            bus.mem_write <= d_mw && !kill;
            bus.wb_en     <= d_wb && !kill;
            bus.b         <= d_b  && !kill;
            bus.s_out     <= d_s  && !kill;
            bus.illegal   <= d_ill;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cond_decode_stage.sv
// Randomised bench for cond_decode_stage with a table-driven reference model
// plus directed scenarios pinned by hand-computed literals.
module tb_cond_decode_stage;
    localparam int FS = 2;
    localparam int NV = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    cond_decode_if #(.CMD_W(4)) ifc ();

    cond_decode_stage #(.CMD_W(4), .FLUSH_SLOTS(FS), .NV_EXECUTES(NV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [3:0] cmd;
        logic       mr, mw, wb, b, s, ill;
    } exp_t;

    exp_t ex;
    int   sh;
    int   dp_cmd [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // ARM conditions come in pairs: odd codes invert the even code below them.
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] st);
        logic n, z, cf, v, base;
        {n, z, cf, v} = st;
        if (c == 4'hF) return (NV != 0);
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? ~base : base;
    endfunction

    function automatic exp_t model_dec(input logic [1:0] m, input logic [3:0] op, input logic s);
        exp_t r;
        r   = '0;
        r.v = 1'b1;
        case (m)
            2'd0: begin
                if (dp_cmd[op] < 0) r.ill = 1'b1;
                else begin
                    r.cmd = 4'(dp_cmd[op]);
                    if (op == 4'd10 || op == 4'd8) r.s = 1'b1;
                    else begin r.wb = 1'b1; r.s = s; end
                end
            end
            2'd1: begin r.cmd = 4'd2; r.mr = s; r.wb = s; r.mw = ~s; end
            2'd2: r.b = 1'b1;
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    // Reference model: tracks what the stage's output register must hold.
    initial begin
        exp_t d;
        logic kl;
        for (int i = 0; i < 16; i++) dp_cmd[i] = -1;
        dp_cmd[13] = 1; dp_cmd[15] = 9; dp_cmd[4] = 2; dp_cmd[5] = 3; dp_cmd[2] = 4;
        dp_cmd[6]  = 5; dp_cmd[0]  = 6; dp_cmd[12] = 7; dp_cmd[1] = 8;
        dp_cmd[10] = 4; dp_cmd[8]  = 6;
        ex = '0;
        sh = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                ex = '0;
                sh = 0;
            end else if (ifc.flush) begin
                ex.v = 1'b0;
                sh   = 0;
            end else if (ifc.in_valid && (!ex.v || ifc.out_ready) && !ifc.hazard) begin
                d  = model_dec(ifc.mode, ifc.op_code, ifc.s_in);
                kl = !d.ill && (!cond_ok(ifc.cond, ifc.status) || sh > 0);
                if (sh > 0) sh--;
                else if (!kl && d.b) sh = FS;
                ex = kl ? exp_t'('0) : d;
            end else if (ifc.out_ready) begin
                ex.v = 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("in_ready", ifc.in_ready,
                (!ex.v || ifc.out_ready) && !ifc.hazard && !ifc.flush);
            chk("out_valid", ifc.out_valid, ex.v);
            if (ex.v) begin
                chk("exe_cmd", ifc.exe_cmd, ex.cmd);
                chk("ctrl", {ifc.mem_read, ifc.mem_write, ifc.wb_en, ifc.b, ifc.s_out, ifc.illegal},
                    {ex.mr, ex.mw, ex.wb, ex.b, ex.s, ex.ill});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [3:0] c, input logic [1:0] m, input logic [3:0] o,
                      input logic s, input logic [3:0] st);
        ifc.in_valid = 1'b1;
        ifc.cond     = c;
        ifc.mode     = m;
        ifc.op_code  = o;
        ifc.s_in     = s;
        ifc.status   = st;
    endtask

    initial begin
        logic [9:0] held;
        ifc.in_valid = 0; ifc.cond = 0; ifc.mode = 0; ifc.op_code = 0; ifc.s_in = 0;
        ifc.status = 0; ifc.hazard = 0; ifc.flush = 0; ifc.out_ready = 1;
        repeat (3) tick();
        chk("rst_state", {ifc.out_valid, ifc.exe_cmd, ifc.mem_read, ifc.mem_write, ifc.wb_en,
                          ifc.b, ifc.s_out, ifc.illegal}, 0);
        rst_n = 1'b1;
        tick();

        // MOV with S set
        op(4'hE, 2'd0, 4'b1101, 1'b1, 4'h0); tick(); ifc.in_valid = 0;
        chk("mov_valid", ifc.out_valid, 1); chk("mov_cmd", ifc.exe_cmd, 4'b0001);
        chk("mov_wb", ifc.wb_en, 1);       chk("mov_s", ifc.s_out, 1);

        // EQ fails with Z=0, then passes with Z=1
        op(4'h0, 2'd0, 4'b0100, 1'b0, 4'b0000); tick();
        chk("eq_fail", ifc.out_valid, 0);
        op(4'h0, 2'd0, 4'b0100, 1'b0, 4'b0100); tick(); ifc.in_valid = 0;
        chk("eq_pass", ifc.out_valid, 1); chk("eq_cmd", ifc.exe_cmd, 4'b0010);

        // Taken branch then three ADDs: two bubbles, third issues
        op(4'hE, 2'd2, 4'h0, 1'b0, 4'h0); tick();
        chk("br_b", ifc.b, 1); chk("br_valid", ifc.out_valid, 1);
        op(4'hE, 2'd0, 4'b0100, 1'b0, 4'h0); tick();
        chk("shadow1", ifc.out_valid, 0); tick();
        chk("shadow2", ifc.out_valid, 0); tick();
        chk("post_shadow", ifc.out_valid, 1); chk("post_cmd", ifc.exe_cmd, 4'b0010);
        ifc.in_valid = 0;

        // EX back-pressure for 3 cycles
        ifc.out_ready = 0;
        op(4'hE, 2'd0, 4'b1101, 1'b0, 4'h0); tick();
        op(4'hE, 2'd0, 4'b0010, 1'b0, 4'h0);
        held = {ifc.out_valid, ifc.exe_cmd, ifc.mem_read, ifc.mem_write, ifc.wb_en, ifc.b, ifc.s_out};
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", {ifc.out_valid, ifc.exe_cmd, ifc.mem_read, ifc.mem_write, ifc.wb_en,
                               ifc.b, ifc.s_out}, held);
            chk("stall_rdy", ifc.in_ready, 0);
        end
        ifc.out_ready = 1; #1;
        chk("release_rdy", ifc.in_ready, 1);
        tick(); ifc.in_valid = 0;
        chk("release_cmd", ifc.exe_cmd, 4'b0100); chk("release_v", ifc.out_valid, 1);

        // Hazard drains the held op then holds off new ones
        ifc.out_ready = 0;
        op(4'hE, 2'd0, 4'b1101, 1'b0, 4'h0); tick();
        ifc.hazard = 1; op(4'hE, 2'd0, 4'b0100, 1'b0, 4'h0); tick();
        chk("hz_hold", ifc.out_valid, 1); chk("hz_rdy", ifc.in_ready, 0);
        ifc.out_ready = 1; tick();
        chk("hz_drain", ifc.out_valid, 0); tick();
        chk("hz_bubble", ifc.out_valid, 0); chk("hz_rdy2", ifc.in_ready, 0);
        ifc.hazard = 0; tick(); ifc.in_valid = 0;
        chk("hz_resume", ifc.exe_cmd, 4'b0010); chk("hz_resume_v", ifc.out_valid, 1);

        // Flush inside a branch shadow clears it
        op(4'hE, 2'd2, 4'h0, 1'b0, 4'h0); tick();
        op(4'hE, 2'd0, 4'b0100, 1'b0, 4'h0); ifc.flush = 1; tick();
        chk("flush_v", ifc.out_valid, 0);
        ifc.flush = 0; tick(); ifc.in_valid = 0;
        chk("flush_clr", ifc.out_valid, 1); chk("flush_cmd", ifc.exe_cmd, 4'b0010);

        // Illegal encodings, NV, and a load
        op(4'hE, 2'd3, 4'h0, 1'b1, 4'h0); tick();
        chk("ill_m3", ifc.illegal, 1); chk("ill_m3_v", ifc.out_valid, 1);
        chk("ill_m3_ctl", {ifc.wb_en, ifc.mem_read, ifc.mem_write}, 0);
        op(4'hE, 2'd0, 4'b0011, 1'b1, 4'h0); tick();
        chk("ill_op3", ifc.illegal, 1); chk("ill_op3_wb", ifc.wb_en, 0);
        op(4'h0, 2'd0, 4'b0011, 1'b0, 4'h0); tick();
        chk("ill_nosquash", ifc.out_valid, 1);
        op(4'hF, 2'd0, 4'b1101, 1'b0, 4'h0); tick();
        chk("nv_fail", ifc.out_valid, 0);
        op(4'hE, 2'd1, 4'h0, 1'b1, 4'h0); tick(); ifc.in_valid = 0;
        chk("ldr", {ifc.mem_read, ifc.mem_write, ifc.wb_en, ifc.exe_cmd}, {3'b101, 4'b0010});

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            ifc.in_valid  = ($urandom_range(0, 9) < 7);
            ifc.cond      = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom);
            ifc.mode      = 2'($urandom);
            ifc.op_code   = 4'($urandom);
            ifc.s_in      = 1'($urandom);
            ifc.status    = 4'($urandom);
            ifc.hazard    = ($urandom_range(0, 9) == 0);
            ifc.flush     = ($urandom_range(0, 19) == 0);
            ifc.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        ifc.hazard = 0; ifc.flush = 0; ifc.out_ready = 1;

        // Asynchronous reset mid-stream
        op(4'hE, 2'd0, 4'b1101, 1'b1, 4'h0); tick();
        #1 rst_n = 1'b0;
        #1 chk("async_rst", {ifc.out_valid, ifc.exe_cmd, ifc.mem_read, ifc.mem_write, ifc.wb_en,
                            ifc.b, ifc.s_out, ifc.illegal}, 0);
        ifc.in_valid = 0;
        tick();
        rst_n = 1'b1;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
